stream_pkt_rr_arbiter: RTL and testbench

- Shares one downstream valid/ready stream between N_INP upstream requesters.
- Arbitration is round-robin at packet granularity: once an input wins, it keeps the grant until its beat with last set is accepted.
- Output is a registered pipeline stage: one-deep, full throughput, no fall-through.
- Sits in front of shared stream registers and FIFOs wherever several masters feed one stream sink.

---
 rtl/stream_arb_pkg.sv | 13 +
 rtl/stream_rr_pick.sv | 31 +++
 rtl/stream_pkt_rr_arbiter.sv | 133 +++++++++++++
 tb/tb_stream_pkt_rr_arbiter.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/stream_arb_pkg.sv
// rtl/stream_arb_pkg.sv - shared types and helpers for the packet stream arbiter
package stream_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

  function automatic int idx_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/stream_rr_pick.sv
// rtl/stream_rr_pick.sv - rotated find-first-set over a valid vector
module stream_rr_pick
  import stream_arb_pkg::*;
#(
  parameter int N = 4,
  localparam int IDX_W = idx_width(N)
) (
  input  logic [N-1:0]     valid_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             found_o
);

  // Lowest valid index overall, then overridden by the lowest valid index at or above ptr_i.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (valid_i[i]) begin
        idx_o   = IDX_W'(i);
        found_o = 1'b1;
      end
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (valid_i[i] && (i >= int'(ptr_i))) begin
        idx_o = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/stream_pkt_rr_arbiter.sv
// rtl/stream_pkt_rr_arbiter.sv - packet-granular round-robin stream arbiter with registered output
module stream_pkt_rr_arbiter
  import stream_arb_pkg::*;
#(
  parameter int N_INP = 4,
  parameter int DATA_WIDTH = 32,
  localparam int IDX_W = idx_width(N_INP)
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             clr_i,
  input  logic [N_INP-1:0]                 inp_valid_i,
  output logic [N_INP-1:0]                 inp_ready_o,
  input  logic [N_INP-1:0][DATA_WIDTH-1:0] inp_data_i,
  input  logic [N_INP-1:0]                 inp_last_i,
  output logic                             oup_valid_o,
  input  logic                             oup_ready_i,
  output logic [DATA_WIDTH-1:0]            oup_data_o,
  output logic                             oup_last_o,
  output logic [IDX_W-1:0]                 oup_idx_o
);

  if (N_INP < 1) begin : g_bad_param
    $error("stream_pkt_rr_arbiter: N_INP must be at least 1");
  end

  arb_state_e             state, state_d;
  logic [IDX_W-1:0]       rr_ptr, rr_ptr_d;
  logic [IDX_W-1:0]       lock_idx, lock_idx_d;
  logic                   full;
  logic [DATA_WIDTH-1:0]  data_q;
  logic                   last_q;
  logic [IDX_W-1:0]       idx_q;

  logic                   take;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_found;
  logic [IDX_W-1:0]       sel_idx;
  logic                   sel_valid;
  logic                   sel_last;
  logic [DATA_WIDTH-1:0]  sel_data;
  logic                   accept;
  logic [IDX_W-1:0]       ptr_inc;

  stream_rr_pick #(
    .N(N_INP)
  ) u_pick (
    .valid_i(inp_valid_i),
    .ptr_i  (rr_ptr),
    .idx_o  (pick_idx),
    .found_o(pick_found)
  );

  assign take = ~full | oup_ready_i;

  always_comb begin
    sel_idx   = pick_idx;
    sel_valid = pick_found;
    if (state == LOCK) begin
      sel_idx   = lock_idx;
      sel_valid = inp_valid_i[lock_idx];
    end
  end

  assign sel_last = inp_last_i[sel_idx];
  assign sel_data = inp_data_i[sel_idx];
  // Reset and clear both suppress the handshake so no upstream beat is dropped unseen.
  assign accept   = take & sel_valid & ~clr_i & ~rst_i;
  assign ptr_inc  = (sel_idx == IDX_W'(N_INP - 1)) ? '0 : sel_idx + 1'b1;

  always_comb begin
    inp_ready_o = '0;
    if (accept) begin
      inp_ready_o[sel_idx] = 1'b1;
    end
  end

  always_comb begin
    state_d    = state;
    rr_ptr_d   = rr_ptr;
    lock_idx_d = lock_idx;
    if (accept) begin
      if (sel_last) begin
        state_d  = IDLE;
        rr_ptr_d = ptr_inc;
      end else begin
        state_d    = LOCK;
        lock_idx_d = sel_idx;
      end
    end
    if (clr_i) begin
      state_d  = IDLE;
      rr_ptr_d = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      lock_idx <= '0;
    end else begin
      state    <= state_d;
      rr_ptr   <= rr_ptr_d;
      lock_idx <= lock_idx_d;
    end
  end

  // Payload is only loaded on capture; a bare pop just drops full and leaves data as-is.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      full   <= 1'b0;
      data_q <= '0;
      last_q <= 1'b0;
      idx_q  <= '0;
    end else if (clr_i) begin
      full <= 1'b0;
    end else if (accept) begin
      full   <= 1'b1;
      data_q <= sel_data;
      last_q <= sel_last;
      idx_q  <= sel_idx;
    end else if (oup_ready_i) begin
      full <= 1'b0;
    end
  end

  assign oup_valid_o = full;
  assign oup_data_o  = data_q;
  assign oup_last_o  = last_q;
  assign oup_idx_o   = idx_q;

endmodule

// File: tb/tb_stream_pkt_rr_arbiter.sv
// tb/tb_stream_pkt_rr_arbiter.sv - self-checking bench for the packet round-robin arbiter
module tb_stream_pkt_rr_arbiter;

  localparam int N = 4;
  localparam int DW = 32;

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
    int            idx;
  } beat_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              clr = 1'b0;
  logic [N-1:0]      inp_valid = '0;
  logic [N-1:0]      inp_ready;
  logic [N-1:0][DW-1:0] inp_data = '0;
  logic [N-1:0]      inp_last = '0;
  logic              oup_valid;
  logic              oup_ready = 1'b1;
  logic [DW-1:0]     oup_data;
  logic              oup_last;
  logic [1:0]        oup_idx;

  int checks = 0;
  int errors = 0;

  beat_t q[$];
  int    pops[$];
  bit    m_lock = 1'b0;
  int    m_lock_idx = 0;
  int    m_rr = 0;

  always #5 clk = ~clk;

  stream_pkt_rr_arbiter #(
    .N_INP(N),
    .DATA_WIDTH(DW)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .clr_i      (clr),
    .inp_valid_i(inp_valid),
    .inp_ready_o(inp_ready),
    .inp_data_i (inp_data),
    .inp_last_i (inp_last),
    .oup_valid_o(oup_valid),
    .oup_ready_i(oup_ready),
    .oup_data_o (oup_data),
    .oup_last_o (oup_last),
    .oup_idx_o  (oup_idx)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_lock = 1'b0;
    m_lock_idx = 0;
    m_rr = 0;
  endtask

  // Packet rule: a locked owner is the only candidate; otherwise first valid scanning cyclically from m_rr.
  function automatic int winner(input logic [N-1:0] v);
    if (m_lock) return v[m_lock_idx] ? m_lock_idx : -1;
    for (int k = 0; k < N; k++) begin
      int c;
      c = (m_rr + k) % N;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  // One clock: drive at the falling edge, check against the model, then advance the model to the next rising edge.
  task automatic step(input logic [N-1:0] v, input logic [N-1:0] l, input logic rdy, input logic c);
    int w;
    bit acc;
    logic [N-1:0] exp_ready;
    @(negedge clk);
    inp_valid = v;
    inp_last  = l;
    oup_ready = rdy;
    clr       = c;
    for (int i = 0; i < N; i++) inp_data[i] = $urandom;
    #1;
    w = winner(v);
    acc = ((q.size() == 0) || rdy) && !c && (w >= 0);
    exp_ready = '0;
    if (acc) exp_ready[w] = 1'b1;
    chk("inp_ready", 64'(inp_ready), 64'(exp_ready));
    chk("oup_valid", 64'(oup_valid), 64'(q.size() != 0));
    if (q.size() != 0) begin
      chk("oup_data", 64'(oup_data), 64'(q[0].d));
      chk("oup_last", 64'(oup_last), 64'(q[0].l));
      chk("oup_idx", 64'(oup_idx), 64'(q[0].idx));
    end
    if ((q.size() != 0) && rdy) begin
      pops.push_back(q[0].idx);
      void'(q.pop_front());
    end
    if (c) begin
      q.delete();
      m_lock = 1'b0;
      m_rr = 0;
    end else if (acc) begin
      q.push_back('{d: inp_data[w], l: l[w], idx: w});
      if (l[w]) begin
        m_lock = 1'b0;
        m_rr = (w + 1) % N;
      end else begin
        m_lock = 1'b1;
        m_lock_idx = w;
      end
    end
  endtask

  initial begin
    int exp_seq[11];
    exp_seq = '{0, 1, 2, 3, 0, 1, 2, 2, 2, 3, 0};

    inp_valid = '1;
    #2;
    chk("rst_ready", 64'(inp_ready), 64'h0);
    chk("rst_valid", 64'(oup_valid), 64'h0);
    chk("rst_data", 64'(oup_data), 64'h0);
    chk("rst_last", 64'(oup_last), 64'h0);
    chk("rst_idx", 64'(oup_idx), 64'h0);
    inp_valid = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    for (int i = 0; i < 5; i++) begin
      step(4'b0000, 4'b0000, 1'b1, 1'b0);
      chk("quiet_idx", 64'(oup_idx), 64'h0);
    end

    pops.delete();
    for (int i = 0; i < 6; i++) step(4'b1111, 4'b1111, 1'b1, 1'b0);
    step(4'b1111, 4'b1011, 1'b1, 1'b0);
    step(4'b1111, 4'b1011, 1'b1, 1'b0);
    step(4'b1111, 4'b1111, 1'b1, 1'b0);
    step(4'b1111, 4'b1111, 1'b1, 1'b0);
    step(4'b1111, 4'b1111, 1'b1, 1'b0);
    step(4'b0000, 4'b0000, 1'b1, 1'b0);
    chk("seq_len", 64'(pops.size()), 64'd11);
    for (int i = 0; i < 11 && i < pops.size(); i++) chk("rr_seq", 64'(pops[i]), 64'(exp_seq[i]));

    pops.delete();
    step(4'b0001, 4'b1111, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(4'b1111, 4'b1111, 1'b0, 1'b0);
      chk("stall_ready", 64'(inp_ready), 64'h0);
    end
    step(4'b0010, 4'b1111, 1'b1, 1'b0);
    step(4'b0000, 4'b0000, 1'b1, 1'b0);
    step(4'b0000, 4'b0000, 1'b1, 1'b0);
    chk("stall_pops", 64'(pops.size()), 64'd2);
    if (pops.size() == 2) begin
      chk("stall_idx0", 64'(pops[0]), 64'd0);
      chk("stall_idx1", 64'(pops[1]), 64'd1);
    end

    step(4'b0010, 4'b0000, 1'b1, 1'b0);
    step(4'b0010, 4'b0000, 1'b1, 1'b1);
    chk("clr_ready", 64'(inp_ready), 64'h0);
    step(4'b1000, 4'b1111, 1'b1, 1'b0);
    chk("post_clr_valid", 64'(oup_valid), 64'h0);
    chk("post_clr_grant", 64'(inp_ready), 64'b1000);
    step(4'b0000, 4'b0000, 1'b1, 1'b0);

    step(4'b1111, 4'b1111, 1'b1, 1'b0);
    @(posedge clk);
    #2;
    chk("pre_rst_valid", 64'(oup_valid), 64'h1);
    rst = 1'b1;
    #1;
    chk("arst_valid", 64'(oup_valid), 64'h0);
    chk("arst_data", 64'(oup_data), 64'h0);
    chk("arst_idx", 64'(oup_idx), 64'h0);
    chk("arst_ready", 64'(inp_ready), 64'h0);
    model_reset();
    inp_valid = '0;
    @(negedge clk);
    rst = 1'b0;
    step(4'b1111, 4'b1111, 1'b1, 1'b0);
    chk("arst_restart", 64'(inp_ready), 64'b0001);

    for (int i = 0; i < 400; i++) begin
      logic [N-1:0] v;
      logic [N-1:0] l;
      v = N'($urandom);
      for (int k = 0; k < N; k++) l[k] = ($urandom_range(0, 2) == 0);
      step(v, l, ($urandom_range(0, 3) != 0), ($urandom_range(0, 31) == 0));
    end
    for (int i = 0; i < 3; i++) step(4'b0000, 4'b0000, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
